// File: rtl/riscv_test_harness_ctrl_pkg.sv
// Shared types for the RISC-V test harness controller: data word type,
// harness FSM states and store-monitor verdict codes.
package riscv_test_harness_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] dataBus_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE
  } harness_state_e;

  typedef enum logic [1:0] {
    V_NONE,
    V_PASS,
    V_FAIL,
    V_TIMEOUT
  } verdict_e;

endpackage

// File: rtl/riscv_test_harness_ctrl_store_monitor.sv
// Classifies a single core data-memory store into a pass/fail/no-action
// verdict by matching the full 32-bit address and the stored word.
module riscv_store_monitor
  import riscv_test_harness_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int unsigned PASS_ADDR   = 100,
  parameter int unsigned PASS_VALUE  = 25,
  parameter int unsigned IGNORE_ADDR = 96,
  parameter bit          STRICT      = 1'b1
) (
  input  logic                  wr_en,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] data,
  output verdict_e              verdict
);

  // The verdict address takes priority, so it still works if it aliases the scratch address.
  always_comb begin
    verdict = V_NONE;
    if (wr_en) begin
      if (addr == 32'(PASS_ADDR)) begin
        verdict = (data == DATA_WIDTH'(PASS_VALUE)) ? V_PASS : V_FAIL;
      end else if (addr == 32'(IGNORE_ADDR)) begin
        verdict = V_NONE;
      end else if (STRICT) begin
        verdict = V_FAIL;
      end
    end
  end

endmodule

// File: rtl/riscv_test_harness_ctrl.sv
// Harness controller: copies a program image into instruction memory, holds
// and then releases core reset, and watches stores for a verdict or a timeout.
module riscv_test_harness_ctrl
  import riscv_test_harness_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH     = riscv_test_harness_ctrl_pkg::DATA_WIDTH,
  parameter int          PROG_WORDS     = 32,
  parameter int          RESET_HOLD     = 2,
  parameter int          TIMEOUT_CYCLES = 1200,
  parameter int unsigned PASS_ADDR      = 100,
  parameter int unsigned PASS_VALUE     = 25,
  parameter int unsigned IGNORE_ADDR    = 96,
  parameter bit          STRICT         = 1'b1,
  localparam int         IDX_W          = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic [IDX_W-1:0]      o_img_addr,
  input  logic [DATA_WIDTH-1:0] i_img_data,
  output logic                  o_init_active,
  output logic                  o_imem_we,
  output logic [3:0]            o_imem_ctrl,
  output logic [31:0]           o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wdata,
  output logic                  o_cpu_rst_n,
  input  logic                  i_data_wr_en,
  input  logic [31:0]           i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wr,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_fail,
  output logic                  o_timeout,
  output logic [31:0]           o_run_cycles
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  harness_state_e    state, state_next;
  logic [IDX_W-1:0]  idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       run_cycles, run_inc;
  logic              pass_q, fail_q, timeout_q, cpu_rst_n_q;
  verdict_e          store_verdict;

  riscv_store_monitor #(
    .DATA_WIDTH (DATA_WIDTH),
    .PASS_ADDR  (PASS_ADDR),
    .PASS_VALUE (PASS_VALUE),
    .IGNORE_ADDR(IGNORE_ADDR),
    .STRICT     (STRICT)
  ) u_store_monitor (
    .wr_en  (i_data_wr_en),
    .addr   (i_data_addr),
    .data   (i_data_wr),
    .verdict(store_verdict)
  );

  assign run_inc = (run_cycles == '1) ? run_cycles : run_cycles + 32'd1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (i_start) state_next = LOAD;
      LOAD:       if (idx == IDX_W'(PROG_WORDS - 1)) state_next = HOLD;
      HOLD:       if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) state_next = RUN;
      RUN: begin
        if (store_verdict != V_NONE || run_inc == 32'(TIMEOUT_CYCLES)) state_next = DONE;
      end
      default:    state_next = IDLE;
    endcase
  end

  // Core reset is registered from the next state so it rises exactly on the first RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      hold_cnt    <= '0;
      run_cycles  <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state       <= state_next;
      cpu_rst_n_q <= (state_next == RUN);
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            idx        <= '0;
            run_cycles <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
        LOAD: begin
          idx      <= (state_next == HOLD) ? '0 : idx + 1'b1;
          hold_cnt <= '0;
        end
        HOLD: hold_cnt <= hold_cnt + 1'b1;
        RUN: begin
          run_cycles <= run_inc;
          if (store_verdict == V_PASS) begin
            pass_q <= 1'b1;
          end else if (store_verdict == V_FAIL) begin
            fail_q <= 1'b1;
          end else if (run_inc == 32'(TIMEOUT_CYCLES)) begin
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_img_addr    = idx;
  assign o_init_active = (state == LOAD);
  assign o_imem_we     = (state == LOAD);
  assign o_imem_ctrl   = (state == LOAD) ? 4'b1111 : 4'b0000;
  assign o_imem_addr   = 32'({idx, 2'b00});
  assign o_imem_wdata  = i_img_data;
  assign o_cpu_rst_n   = cpu_rst_n_q;
  assign o_done        = (state == DONE);
  assign o_pass        = pass_q;
  assign o_fail        = fail_q;
  assign o_timeout     = timeout_q;
  assign o_run_cycles  = run_cycles;

endmodule

// File: tb/tb_riscv_test_harness_ctrl.sv
// Scoreboard bench for riscv_test_harness_ctrl: strict and lax instances share
// stimulus; expected writes and verdicts are queued and checked as they appear.
module tb_riscv_test_harness_ctrl;

  localparam int PW = 4;
  localparam int DW = 32;
  localparam int AW = $clog2(PW);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } write_t;

  typedef struct {
    logic [2:0]  flags;
    logic [31:0] cycles;
  } verdict_t;

  logic clk = 1'b0;
  logic rst_n, i_start, i_data_wr_en;
  logic [31:0] i_data_addr;
  logic [DW-1:0] i_data_wr, img_data, l_img_data;

  logic [AW-1:0] o_img_addr, l_img_addr;
  logic o_init_active, o_imem_we, o_cpu_rst_n, o_done, o_pass, o_fail, o_timeout;
  logic l_init_active, l_imem_we, l_cpu_rst_n, l_done, l_pass, l_fail, l_timeout;
  logic [3:0] o_imem_ctrl, l_imem_ctrl;
  logic [31:0] o_imem_addr, l_imem_addr, o_run_cycles, l_run_cycles;
  logic [DW-1:0] o_imem_wdata, l_imem_wdata;

  logic [31:0] cur_img [PW];
  write_t   wq[$];
  verdict_t vq[$];
  int check_count = 0;
  int pass_count = 0;
  int run_pos = 0;

  always #5 clk = ~clk;

  assign img_data   = cur_img[o_img_addr];
  assign l_img_data = cur_img[l_img_addr];

  riscv_test_harness_ctrl #(
    .DATA_WIDTH(DW), .PROG_WORDS(PW), .RESET_HOLD(2), .TIMEOUT_CYCLES(10),
    .PASS_ADDR(100), .PASS_VALUE(25), .IGNORE_ADDR(96), .STRICT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_img_addr(o_img_addr), .i_img_data(img_data),
    .o_init_active(o_init_active), .o_imem_we(o_imem_we), .o_imem_ctrl(o_imem_ctrl),
    .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata), .o_cpu_rst_n(o_cpu_rst_n),
    .i_data_wr_en(i_data_wr_en), .i_data_addr(i_data_addr), .i_data_wr(i_data_wr),
    .o_done(o_done), .o_pass(o_pass), .o_fail(o_fail), .o_timeout(o_timeout),
    .o_run_cycles(o_run_cycles)
  );

  riscv_test_harness_ctrl #(
    .DATA_WIDTH(DW), .PROG_WORDS(PW), .RESET_HOLD(2), .TIMEOUT_CYCLES(10),
    .PASS_ADDR(100), .PASS_VALUE(25), .IGNORE_ADDR(96), .STRICT(1'b0)
  ) dut_lax (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .o_img_addr(l_img_addr), .i_img_data(l_img_data),
    .o_init_active(l_init_active), .o_imem_we(l_imem_we), .o_imem_ctrl(l_imem_ctrl),
    .o_imem_addr(l_imem_addr), .o_imem_wdata(l_imem_wdata), .o_cpu_rst_n(l_cpu_rst_n),
    .i_data_wr_en(i_data_wr_en), .i_data_addr(i_data_addr), .i_data_wr(i_data_wr),
    .o_done(l_done), .o_pass(l_pass), .o_fail(l_fail), .o_timeout(l_timeout),
    .o_run_cycles(l_run_cycles)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    run_pos++;
  endtask

  task automatic loadImage(input logic [31:0] base);
    for (int i = 0; i < PW; i++) cur_img[i] = base + 32'(i);
  endtask

  task automatic startRun();
    for (int i = 0; i < PW; i++) wq.push_back('{addr: 32'(4 * i), data: cur_img[i]});
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Called on the first LOAD cycle; returns on the first RUN cycle.
  task automatic waitLoadAndHold();
    int load_len = 0;
    int hold_len = 0;
    checkOutput("init_active", {31'd0, o_init_active}, 32'd1);
    checkOutput("imem_ctrl", {28'd0, o_imem_ctrl}, 32'hF);
    while (o_imem_we && load_len < 100) begin
      load_len++;
      tick();
    end
    checkOutput("load_len", 32'(load_len), 32'(PW));
    while (!o_cpu_rst_n && hold_len < 100) begin
      hold_len++;
      tick();
    end
    checkOutput("hold_len", 32'(hold_len), 32'd2);
    run_pos = 1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input bit push, input logic [2:0] flags);
    i_data_wr_en = 1'b1;
    i_data_addr  = addr;
    i_data_wr    = data;
    if (push) vq.push_back('{flags: flags, cycles: 32'(run_pos)});
    tick();
    i_data_wr_en = 1'b0;
  endtask

  // Scoreboard side: pops expected writes and verdicts as the DUT produces them.
  initial begin
    logic prev_done;
    write_t w;
    verdict_t v;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_done = 1'b0;
        continue;
      end
      if (o_imem_we) begin
        if (wq.size() == 0) checkOutput("write_unexpected", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          checkOutput("load_addr", o_imem_addr, w.addr);
          checkOutput("load_data", o_imem_wdata, w.data);
        end
      end
      if (o_done && !prev_done) begin
        if (vq.size() == 0) checkOutput("verdict_unexpected", 32'd1, 32'd0);
        else begin
          v = vq.pop_front();
          checkOutput("verdict_flags", {29'd0, o_pass, o_fail, o_timeout}, {29'd0, v.flags});
          checkOutput("run_cycles", o_run_cycles, v.cycles);
        end
      end
      prev_done = o_done;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_data_wr_en = 1'b0;
    i_data_addr = '0;
    i_data_wr = '0;
    loadImage(32'hA000_00A0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);
    checkOutput("rst_flags", {28'd0, o_done, o_pass, o_fail, o_timeout}, 32'd0);
    checkOutput("rst_imem", {27'd0, o_init_active, o_imem_we, o_imem_ctrl}, 32'd0);
    checkOutput("rst_counts", o_run_cycles | 32'(o_img_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] load, scratch store, pass store");
    startRun();
    waitLoadAndHold();
    applyStimulus(32'd96, 32'd7, 1'b0, 3'b000);
    checkOutput("scratch_no_done", {31'd0, o_done}, 32'd0);
    applyStimulus(32'd100, 32'd25, 1'b1, 3'b100);
    checkOutput("pass_done", {30'd0, o_done, o_pass}, 32'd3);
    checkOutput("done_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);
    tick();

    $display("[TB] reload and wrong pass value");
    loadImage(32'hB000_00B0);
    startRun();
    checkOutput("flags_clear", {28'd0, o_done, o_pass, o_fail, o_timeout}, 32'd0);
    waitLoadAndHold();
    applyStimulus(32'd100, 32'd24, 1'b1, 3'b010);
    checkOutput("bad_value_fail", {31'd0, o_fail}, 32'd1);
    tick();

    $display("[TB] stray store strict vs lax");
    startRun();
    waitLoadAndHold();
    applyStimulus(32'd200, 32'd1, 1'b1, 3'b010);
    checkOutput("strict_fail", {31'd0, o_fail}, 32'd1);
    checkOutput("lax_ignores", {31'd0, l_done}, 32'd0);
    applyStimulus(32'd100, 32'd25, 1'b0, 3'b000);
    checkOutput("lax_pass", {30'd0, l_done, l_pass}, 32'd3);
    checkOutput("strict_stays_fail", {30'd0, o_pass, o_fail}, 32'd1);
    tick();

    $display("[TB] start during run ignored");
    startRun();
    waitLoadAndHold();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checkOutput("start_in_run", {30'd0, o_cpu_rst_n, o_imem_we}, 32'd2);
    applyStimulus(32'd100, 32'd25, 1'b1, 3'b100);
    tick();

    $display("[TB] timeout");
    startRun();
    waitLoadAndHold();
    vq.push_back('{flags: 3'b001, cycles: 32'd10});
    guard = 0;
    while (!o_done && guard < 50) begin
      guard++;
      tick();
    end
    checkOutput("timeout_seen", {31'd0, o_timeout}, 32'd1);
    checkOutput("timeout_cycles", o_run_cycles, 32'd10);
    tick();

    $display("[TB] pass store on the timeout cycle");
    startRun();
    waitLoadAndHold();
    repeat (9) tick();
    applyStimulus(32'd100, 32'd25, 1'b1, 3'b100);
    checkOutput("pass_beats_timeout", {29'd0, o_pass, o_fail, o_timeout}, 32'd4);
    tick();

    $display("[TB] reset during load, then restart");
    loadImage(32'hC000_00C0);
    startRun();
    tick();
    tick();
    checkOutput("mid_load_word", 32'(o_img_addr), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_imem", {27'd0, o_init_active, o_imem_we, o_imem_ctrl}, 32'd0);
    checkOutput("async_rst_state", {29'd0, o_done, o_cpu_rst_n, 1'b0} | 32'(o_img_addr), 32'd0);
    wq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    startRun();
    waitLoadAndHold();
    applyStimulus(32'd100, 32'd25, 1'b1, 3'b100);
    tick();
    tick();

    checkOutput("writes_left", 32'(wq.size()), 32'd0);
    checkOutput("verdicts_left", 32'(vq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
